// File: rtl/piece_mover.sv
// -----------------------------------------------------------------------------
// piece_mover
//   Sequences one falling tetromino through spawn, move/rotate/drop commands and
//   locking. Each proposed position is registered on cand_ctrl, and an external
//   combinational checker judges it on cand_ok in the following cycle.
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   spawn_valid/ctrl: new piece offer (accepted only while spawn_ready)
//   spawn_ready     : high only in IDLE
//   cmd_valid/cmd   : move command offer (accepted only while cmd_ready)
//   cmd_ready       : high only in READY
//   cand_ctrl       : registered candidate presented to the validity checker
//   cand_ok         : checker verdict for cand_ctrl
//   curr_ctrl       : committed active piece
//   active          : a piece is in play
//   lock_valid      : one-cycle pulse; lock_ctrl is the piece to merge
//   game_over       : sticky, set when a spawn collides
//
// Build option
//   WALL_KICK_EN    : when defined, a rejected rotation is retried at x-1 and
//                     then at x+1 before being abandoned.
// -----------------------------------------------------------------------------
package piece_mover_pkg;

  typedef struct packed {
    logic [2:0]        piece;
    logic signed [4:0] x;
    logic [5:0]        y;
    logic [1:0]        rotation;
  } tetromino_ctrl;

  localparam logic [2:0] CMD_LEFT      = 3'd0;
  localparam logic [2:0] CMD_RIGHT     = 3'd1;
  localparam logic [2:0] CMD_ROT_CW    = 3'd2;
  localparam logic [2:0] CMD_ROT_CCW   = 3'd3;
  localparam logic [2:0] CMD_SOFT_DROP = 3'd4;
  localparam logic [2:0] CMD_HARD_DROP = 3'd5;
  localparam logic [2:0] CMD_GRAVITY   = 3'd6;

endpackage

module piece_mover
  import piece_mover_pkg::*;
#(
  parameter int DROP_LIMIT = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spawn_valid,
  input  tetromino_ctrl spawn_ctrl,
  output logic          spawn_ready,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  output logic          cmd_ready,
  output tetromino_ctrl cand_ctrl,
  input  logic          cand_ok,
  output tetromino_ctrl curr_ctrl,
  output logic          active,
  output logic          lock_valid,
  output tetromino_ctrl lock_ctrl,
  output logic          game_over
);

  localparam int STEP_W = $clog2(DROP_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN_CHK = 3'd1,
    READY     = 3'd2,
    CHECK     = 3'd3,
`ifdef WALL_KICK_EN
    KICK_L    = 3'd4,
    KICK_R    = 3'd5,
`endif
    LOCK      = 3'd6,
    OVER      = 3'd7
  } state_e;

  state_e              state_q, state_d;
  tetromino_ctrl       cand_q, cand_d;
  tetromino_ctrl       curr_q, curr_d;
  tetromino_ctrl       lock_ctrl_q, lock_ctrl_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   step_inc;
  logic                active_q, active_d;
  logic                lock_valid_q, lock_valid_d;
  logic                game_over_q, game_over_d;
  logic                spawn_ready_q, spawn_ready_d;
  logic                cmd_ready_q, cmd_ready_d;

  function automatic tetromino_ctrl f_with_x(input tetromino_ctrl c,
                                              input logic signed [4:0] x);
    tetromino_ctrl r;
    r   = c;
    r.x = x;
    return r;
  endfunction

  function automatic tetromino_ctrl f_with_y(input tetromino_ctrl c,
                                              input logic [5:0] y);
    tetromino_ctrl r;
    r   = c;
    r.y = y;
    return r;
  endfunction

  function automatic tetromino_ctrl f_with_rot(input tetromino_ctrl c,
                                                input logic [1:0] rot);
    tetromino_ctrl r;
    r          = c;
    r.rotation = rot;
    return r;
  endfunction

  assign step_inc = step_q + {{(STEP_W-1){1'b0}}, 1'b1};

  // Next-state and next-output computation for the piece sequencer
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    curr_d        = curr_q;
    lock_ctrl_d   = lock_ctrl_q;
    cmd_d         = cmd_q;
    step_d        = step_q;
    active_d      = active_q;
    lock_valid_d  = 1'b0;
    game_over_d   = game_over_q;

    case (state_q)
      IDLE: begin
        if (spawn_valid) begin
          cand_d  = spawn_ctrl;
          state_d = SPAWN_CHK;
        end else begin
          state_d = IDLE;
        end
      end

      SPAWN_CHK: begin
        if (cand_ok) begin
          curr_d   = cand_q;
          active_d = 1'b1;
          state_d  = READY;
        end else begin
          game_over_d = 1'b1;
          state_d     = OVER;
        end
      end

      READY: begin
        if (cmd_valid) begin
          cmd_d   = cmd;
          step_d  = {STEP_W{1'b0}};
          state_d = CHECK;
          case (cmd)
            CMD_LEFT:      cand_d = f_with_x(curr_q, curr_q.x - 5'sd1);
            CMD_RIGHT:     cand_d = f_with_x(curr_q, curr_q.x + 5'sd1);
            CMD_ROT_CW:    cand_d = f_with_rot(curr_q, curr_q.rotation + 2'd1);
            CMD_ROT_CCW:   cand_d = f_with_rot(curr_q, curr_q.rotation - 2'd1);
            CMD_SOFT_DROP,
            CMD_HARD_DROP,
            CMD_GRAVITY:   cand_d = f_with_y(curr_q, curr_q.y + 6'd1);
            // reserved code: re-check the current position, a no-op move
            default:       cand_d = curr_q;
          endcase
        end else begin
          state_d = READY;
        end
      end

      CHECK: begin
        if (cand_ok) begin
          curr_d = cand_q;
          if (cmd_q == CMD_HARD_DROP) begin
            step_d = step_inc;
            // keep falling one row per cycle until blocked or out of steps
            if (step_inc < STEP_W'(DROP_LIMIT)) begin
              cand_d  = f_with_y(cand_q, cand_q.y + 6'd1);
              state_d = CHECK;
            end else begin
              state_d = LOCK;
            end
          end else begin
            state_d = READY;
          end
        end else begin
          case (cmd_q)
            CMD_SOFT_DROP,
            CMD_HARD_DROP,
            CMD_GRAVITY: state_d = LOCK;
`ifdef WALL_KICK_EN
            CMD_ROT_CW,
            CMD_ROT_CCW: begin
              // keep the new rotation, shift one column left of the committed x
              cand_d  = f_with_x(cand_q, curr_q.x - 5'sd1);
              state_d = KICK_L;
            end
`endif
            default:     state_d = READY;
          endcase
        end
      end

`ifdef WALL_KICK_EN
      KICK_L: begin
        if (cand_ok) begin
          curr_d  = cand_q;
          state_d = READY;
        end else begin
          cand_d  = f_with_x(cand_q, curr_q.x + 5'sd1);
          state_d = KICK_R;
        end
      end

      KICK_R: begin
        if (cand_ok) begin
          curr_d  = cand_q;
          state_d = READY;
        end else begin
          state_d = READY;
        end
      end
`endif

      LOCK: begin
        lock_valid_d = 1'b1;
        lock_ctrl_d  = curr_q;
        active_d     = 1'b0;
        state_d      = IDLE;
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    spawn_ready_d = (state_d == IDLE);
    cmd_ready_d   = (state_d == READY);
  end

  // State and registered output update; reset wins over every transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cand_q        <= '0;
      curr_q        <= '0;
      lock_ctrl_q   <= '0;
      cmd_q         <= 3'd0;
      step_q        <= {STEP_W{1'b0}};
      active_q      <= 1'b0;
      lock_valid_q  <= 1'b0;
      game_over_q   <= 1'b0;
      spawn_ready_q <= 1'b1;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      curr_q        <= curr_d;
      lock_ctrl_q   <= lock_ctrl_d;
      cmd_q         <= cmd_d;
      step_q        <= step_d;
      active_q      <= active_d;
      lock_valid_q  <= lock_valid_d;
      game_over_q   <= game_over_d;
      spawn_ready_q <= spawn_ready_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign spawn_ready = spawn_ready_q;
  assign cmd_ready   = cmd_ready_q;
  assign cand_ctrl   = cand_q;
  assign curr_ctrl   = curr_q;
  assign active      = active_q;
  assign lock_valid  = lock_valid_q;
  assign lock_ctrl   = lock_ctrl_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_piece_mover.sv
// -----------------------------------------------------------------------------
// tb_piece_mover
//   Self-checking bench for piece_mover. The validity checker is modelled as a
//   simple rectangular field (x in 0..x_max, y <= y_max) with an optional
//   "narrow" zone where odd rotations do not fit beyond column 7. A behavioural
//   model predicts the result of each command directly from the game rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piece_mover;
  import piece_mover_pkg::*;

  localparam int LIMIT = 31;

  logic          clk;
  logic          rst;
  logic          spawn_valid;
  tetromino_ctrl spawn_ctrl;
  logic          spawn_ready;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic          cmd_ready;
  tetromino_ctrl cand_ctrl;
  logic          cand_ok;
  tetromino_ctrl curr_ctrl;
  logic          active;
  logic          lock_valid;
  tetromino_ctrl lock_ctrl;
  logic          game_over;

  int n_checks = 0;
  int n_fail   = 0;

  int x_max     = 9;
  int y_max     = 19;
  bit kick_zone = 1'b0;

  int            lock_cnt = 0;
  tetromino_ctrl last_lock;
  tetromino_ctrl m_curr;

  piece_mover #(.DROP_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .spawn_valid(spawn_valid),
    .spawn_ctrl (spawn_ctrl),
    .spawn_ready(spawn_ready),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .cand_ctrl  (cand_ctrl),
    .cand_ok    (cand_ok),
    .curr_ctrl  (curr_ctrl),
    .active     (active),
    .lock_valid (lock_valid),
    .lock_ctrl  (lock_ctrl),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit fits(input tetromino_ctrl c, input int xm, input int ym, input bit kz);
    int x;
    x = int'(c.x);
    if (x < 0 || x > xm) return 1'b0;
    if (int'(c.y) > ym) return 1'b0;
    if (kz && c.rotation[0] && x > 7) return 1'b0;
    return 1'b1;
  endfunction

  always_comb cand_ok = fits(cand_ctrl, x_max, y_max, kick_zone);

  // count lock pulses (value held during the previous cycle)
  always @(posedge clk) begin
    if (lock_valid) begin
      lock_cnt  <= lock_cnt + 1;
      last_lock <= lock_ctrl;
    end
  end

  function automatic tetromino_ctrl mk(input int piece, input int x, input int y, input int rot);
    tetromino_ctrl c;
    c.piece    = 3'(piece);
    c.x        = 5'(x);
    c.y        = 6'(y);
    c.rotation = 2'(rot);
    return c;
  endfunction

  // rule-level prediction of one command: new committed piece and whether it locks
  function automatic void model_step(input tetromino_ctrl cur, input int c, input int xm,
                                     input int ym, input bit kz,
                                     output tetromino_ctrl nxt, output bit locked);
    tetromino_ctrl t;
    int x;
    int steps;
    x = int'(cur.x);
    nxt = cur;
    locked = 1'b0;
    t = cur;
    case (c)
      0: begin t.x = 5'(x - 1); if (fits(t, xm, ym, kz)) nxt = t; end
      1: begin t.x = 5'(x + 1); if (fits(t, xm, ym, kz)) nxt = t; end
      2, 3: begin
        t.rotation = 2'((int'(cur.rotation) + ((c == 2) ? 1 : 3)) % 4);
        if (fits(t, xm, ym, kz)) nxt = t;
`ifdef WALL_KICK_EN
        else begin
          t.x = 5'(x - 1);
          if (fits(t, xm, ym, kz)) nxt = t;
          else begin
            t.x = 5'(x + 1);
            if (fits(t, xm, ym, kz)) nxt = t;
          end
        end
`endif
      end
      4, 6: begin
        t.y = 6'(int'(cur.y) + 1);
        if (fits(t, xm, ym, kz)) nxt = t; else locked = 1'b1;
      end
      5: begin
        steps = 0;
        while (steps < LIMIT) begin
          t = nxt;
          t.y = 6'(int'(nxt.y) + 1);
          if (!fits(t, xm, ym, kz)) break;
          nxt = t;
          steps++;
        end
        locked = 1'b1;
      end
      default: nxt = cur;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; spawn_valid = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; spawn_ctrl = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic spawn_piece(input tetromino_ctrl c);
    spawn_valid = 1'b1; spawn_ctrl = c;
    @(negedge clk);
    spawn_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [2:0] c);
    cmd_valid = 1'b1; cmd = c;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!(cmd_ready || spawn_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) begin n_fail++; $display("FAIL %s: no ready after %0d cycles, want <200", tag, n); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL rst_spawn_ready: got %b want 1", spawn_ready); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_checks++; if ({active, lock_valid, game_over} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {active, lock_valid, game_over}); end
    n_checks++; if ({cand_ctrl, curr_ctrl, lock_ctrl} !== 48'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", {cand_ctrl, curr_ctrl, lock_ctrl}); end
  endtask

  task automatic test_spawn_ok();
    tetromino_ctrl c;
    do_reset(); x_max = 9; y_max = 19; kick_zone = 1'b0;
    c = mk(2, 3, 0, 0);
    spawn_valid = 1'b1; spawn_ctrl = c;
    @(negedge clk);
    spawn_valid = 1'b0;
    n_checks++; if (cand_ctrl !== c) begin n_fail++; $display("FAIL spawn_cand: got %h want %h", cand_ctrl, c); end
    n_checks++; if ({active, cmd_ready, spawn_ready} !== 3'b000) begin n_fail++; $display("FAIL spawn_mid: got %b want 000", {active, cmd_ready, spawn_ready}); end
    @(negedge clk);
    n_checks++; if ({active, cmd_ready} !== 2'b11) begin n_fail++; $display("FAIL spawn_active: got %b want 11", {active, cmd_ready}); end
    n_checks++; if (curr_ctrl !== c) begin n_fail++; $display("FAIL spawn_curr: got %h want %h", curr_ctrl, c); end
  endtask

  task automatic test_game_over();
    tetromino_ctrl c;
    do_reset(); x_max = 2;
    c = mk(2, 3, 0, 0);
    spawn_piece(c);
    n_checks++; if ({game_over, active, spawn_ready, cmd_ready} !== 4'b1000) begin n_fail++; $display("FAIL over_flags: got %b want 1000", {game_over, active, spawn_ready, cmd_ready}); end
    x_max = 9;
    spawn_valid = 1'b1; spawn_ctrl = mk(1, 1, 0, 0); cmd_valid = 1'b1; cmd = 3'd1;
    repeat (4) @(negedge clk);
    spawn_valid = 1'b0; cmd_valid = 1'b0;
    n_checks++; if ({game_over, active, spawn_ready, cmd_ready} !== 4'b1000) begin n_fail++; $display("FAIL over_sticky: got %b want 1000", {game_over, active, spawn_ready, cmd_ready}); end
    n_checks++; if (cand_ctrl !== c) begin n_fail++; $display("FAIL over_ignore: got %h want %h", cand_ctrl, c); end
  endtask

  task automatic test_left_wall();
    tetromino_ctrl c;
    int base;
    do_reset(); x_max = 9; y_max = 19;
    c = mk(1, 0, 4, 2);
    spawn_piece(c);
    base = lock_cnt;
    send_cmd(CMD_LEFT);
    n_checks++; if (cand_ctrl.x !== -5'sd1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL left_cand: got x=%0d rdy=%b want x=-1 rdy=0", cand_ctrl.x, cmd_ready); end
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL left_ready: got %b want 1", cmd_ready); end
    n_checks++; if (curr_ctrl !== c) begin n_fail++; $display("FAIL left_curr: got %h want %h", curr_ctrl, c); end
    @(negedge clk);
    n_checks++; if (lock_cnt !== base || active !== 1'b1) begin n_fail++; $display("FAIL left_nolock: got locks=%0d act=%b want %0d 1", lock_cnt, active, base); end
  endtask

  task automatic test_rotate_wrap();
    do_reset(); x_max = 9; y_max = 19; kick_zone = 1'b0;
    spawn_piece(mk(4, 4, 0, 3));
    send_cmd(CMD_ROT_CW);
    n_checks++; if (cand_ctrl.rotation !== 2'd0) begin n_fail++; $display("FAIL rot_cw_wrap: got %0d want 0", cand_ctrl.rotation); end
    @(negedge clk);
    n_checks++; if (curr_ctrl.rotation !== 2'd0) begin n_fail++; $display("FAIL rot_cw_commit: got %0d want 0", curr_ctrl.rotation); end
    send_cmd(CMD_ROT_CCW);
    n_checks++; if (cand_ctrl.rotation !== 2'd3) begin n_fail++; $display("FAIL rot_ccw_wrap: got %0d want 3", cand_ctrl.rotation); end
    @(negedge clk);
    n_checks++; if (curr_ctrl !== mk(4, 4, 0, 3)) begin n_fail++; $display("FAIL rot_ccw_commit: got %h want %h", curr_ctrl, mk(4, 4, 0, 3)); end
  endtask

  task automatic test_hard_drop(input int ym, input int want_y);
    int base;
    do_reset(); x_max = 9; y_max = ym;
    spawn_piece(mk(5, 4, 0, 1));
    base = lock_cnt;
    send_cmd(CMD_HARD_DROP);
    wait_ready("hard_wait");
    @(negedge clk);
    n_checks++; if (lock_cnt !== base + 1) begin n_fail++; $display("FAIL hard_pulses: got %0d want %0d", lock_cnt - base, 1); end
    n_checks++; if (last_lock !== mk(5, 4, want_y, 1)) begin n_fail++; $display("FAIL hard_lock_ctrl: got %h want %h", last_lock, mk(5, 4, want_y, 1)); end
    n_checks++; if ({active, spawn_ready} !== 2'b01) begin n_fail++; $display("FAIL hard_after: got %b want 01", {active, spawn_ready}); end
    y_max = 19;
  endtask

  task automatic test_wall_kick(input int x0, input tetromino_ctrl want);
    do_reset(); x_max = 9; y_max = 19; kick_zone = 1'b1;
    spawn_piece(mk(6, x0, 0, 0));
    send_cmd(CMD_ROT_CW);
    wait_ready("kick_wait");
    n_checks++; if (curr_ctrl !== want || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL kick_x%0d: got %h rdy=%b want %h", x0, curr_ctrl, cmd_ready, want); end
    kick_zone = 1'b0;
  endtask

  task automatic test_rst_mid_drop();
    int base;
    do_reset(); x_max = 9; y_max = 50;
    spawn_piece(mk(3, 2, 0, 0));
    base = lock_cnt;
    send_cmd(CMD_HARD_DROP);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({active, lock_valid, game_over, cmd_ready, spawn_ready} !== 5'b00001) begin n_fail++; $display("FAIL rstdrop_flags: got %b want 00001", {active, lock_valid, game_over, cmd_ready, spawn_ready}); end
    n_checks++; if ({cand_ctrl, curr_ctrl, lock_ctrl} !== 48'h0) begin n_fail++; $display("FAIL rstdrop_ctrl: got %h want 0", {cand_ctrl, curr_ctrl, lock_ctrl}); end
    repeat (40) @(negedge clk);
    n_checks++; if (lock_cnt !== base) begin n_fail++; $display("FAIL rstdrop_nolock: got %0d pulses want 0", lock_cnt - base); end
    y_max = 19;
  endtask

  task automatic test_back_to_back();
    do_reset(); x_max = 9; y_max = 19;
    spawn_piece(mk(0, 2, 0, 0));
    // hold both requests for four cycles: exactly two moves, no spawn
    cmd_valid = 1'b1; cmd = CMD_RIGHT; spawn_valid = 1'b1; spawn_ctrl = mk(7, 9, 9, 1);
    repeat (4) @(negedge clk);
    cmd_valid = 1'b0; spawn_valid = 1'b0;
    n_checks++; if (curr_ctrl !== mk(0, 4, 0, 0) || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b: got %h rdy=%b want %h", curr_ctrl, cmd_ready, mk(0, 4, 0, 0)); end
  endtask

  task automatic test_random();
    tetromino_ctrl c, exp_c;
    bit locked;
    int base, cv;
    do_reset(); x_max = 9; y_max = 19;
    for (int p = 0; p < 12; p++) begin
      kick_zone = bit'($urandom_range(0, 1));
      c = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, int'($urandom_range(0, 3)));
      m_curr = c;
      spawn_piece(c);
      n_checks++; if (curr_ctrl !== c || active !== 1'b1) begin n_fail++; $display("FAIL rand_spawn: got %h act=%b want %h", curr_ctrl, active, c); end
      for (int k = 0; k < 16; k++) begin
        cv = int'($urandom_range(0, 7));
        if (cv == 5 && $urandom_range(0, 3) != 0) cv = 6;
        if (k == 15) cv = 5;
        model_step(m_curr, cv, x_max, y_max, kick_zone, exp_c, locked);
        base = lock_cnt;
        send_cmd(3'(cv));
        wait_ready("rand_wait");
        @(negedge clk);
        n_checks++; if (lock_cnt !== base + (locked ? 1 : 0)) begin n_fail++; $display("FAIL rand_locks cmd=%0d: got %0d want %0d", cv, lock_cnt - base, locked ? 1 : 0); end
        if (locked) begin
          n_checks++; if (last_lock !== exp_c || active !== 1'b0) begin n_fail++; $display("FAIL rand_lock cmd=%0d: got %h act=%b want %h", cv, last_lock, active, exp_c); end
          break;
        end else begin
          n_checks++; if (curr_ctrl !== exp_c || active !== 1'b1) begin n_fail++; $display("FAIL rand_move cmd=%0d: got %h act=%b want %h", cv, curr_ctrl, active, exp_c); end
        end
        m_curr = exp_c;
      end
    end
    kick_zone = 1'b0;
  endtask

  initial begin
    rst = 1'b1; spawn_valid = 1'b0; spawn_ctrl = '0; cmd_valid = 1'b0; cmd = 3'd0;
    test_reset();
    test_spawn_ok();
    test_game_over();
    test_left_wall();
    test_rotate_wrap();
    test_hard_drop(17, 17);
    test_hard_drop(50, LIMIT);
`ifdef WALL_KICK_EN
    test_wall_kick(8, mk(6, 7, 0, 1));
`else
    test_wall_kick(8, mk(6, 8, 0, 0));
`endif
    test_wall_kick(9, mk(6, 9, 0, 0));
    test_rst_mid_drop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
